// File: rtl/aes_model_pack.sv
// Shared AES model definitions: state layout, forward/inverse S-box tables and
// the SubBytes engine state encoding.
package aes_model_pack;

    localparam int COLUMN_COUNT         = 4;
    localparam int COLUMN_SIZE_IN_BYTES = 4;
    localparam int BLOCK_SIZE_IN_BYTES  = COLUMN_COUNT * COLUMN_SIZE_IN_BYTES;

    // Byte n of the state lives at [n / COLUMN_SIZE_IN_BYTES][n % COLUMN_SIZE_IN_BYTES],
    // i.e. at bits n*8 +: 8 of the flattened 128-bit vector.
    typedef logic [COLUMN_COUNT-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] byte_table;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SUB_BYTES_TABLE [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_seq_sbox_lane.sv
// One combinational S-box lane: forward or inverse byte substitution by table lookup.
module sbox_lane
    import aes_model_pack::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] i_byte,
    input  logic       i_inverse,
    output logic [7:0] o_byte
);

    assign o_byte = (INV_EN && i_inverse) ? INV_SUB_BYTES_TABLE[i_byte]
                                          : SUB_BYTES_TABLE[i_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes engine: substitutes a 16-byte state LANES bytes per cycle,
// with valid/ready handshakes on both sides and a per-block forward/inverse mode.
module sub_bytes_seq
    import aes_model_pack::*;
#(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    output logic      in_ready,
    input  byte_table in_block,
    input  logic      in_inverse,
    output logic      out_valid,
    input  logic      out_ready,
    output byte_table out_block,
    output logic      busy
);

    localparam int STEPS   = BLOCK_SIZE_IN_BYTES / LANES;
    localparam int CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W   = $clog2(BLOCK_SIZE_IN_BYTES);
    localparam int BLOCK_W = 8 * BLOCK_SIZE_IN_BYTES;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16, got %0d", LANES);
    end

    sub_state_t         r_state;
    sub_state_t         w_state_next;
    logic [CNT_W-1:0]   r_step;
    logic               r_inv;
    logic [BLOCK_W-1:0] r_work;
    logic [BLOCK_W-1:0] w_work_next;
    logic               w_load;
    logic               w_advance;
    logic               w_last;
    logic [7:0]         w_lane_in  [LANES];
    logic [7:0]         w_lane_out [LANES];

    assign w_last = (r_step == LAST_STEP);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] w_idx;
        logic [IDX_W+2:0] w_bit;

        assign w_idx        = IDX_W'(int'(r_step) * LANES + l);
        assign w_bit        = {w_idx, 3'b000};
        assign w_lane_in[l] = r_work[w_bit +: 8];

        sbox_lane #(
            .INV_EN (INV_EN)
        ) u_sbox (
            .i_byte    (w_lane_in[l]),
            .i_inverse (r_inv),
            .o_byte    (w_lane_out[l])
        );
    end

    // Byte n is owned by lane n%LANES and is rewritten during step n/LANES.
    always_comb begin
        w_work_next = r_work;
        for (int n = 0; n < BLOCK_SIZE_IN_BYTES; n++) begin
            if (r_step == CNT_W'(n / LANES)) begin
                w_work_next[n*8 +: 8] = w_lane_out[n % LANES];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_advance = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // A new block may be taken in the same cycle the result leaves.
                if (out_ready) begin
                    if (in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = BUSY;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_inv   <= 1'b0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_work <= in_block;
                r_inv  <= INV_EN & in_inverse;
                r_step <= '0;
            end else if (w_advance) begin
                r_work <= w_work_next;
                r_step <= w_last ? '0 : r_step + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY);
    assign out_block = r_work;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed and randomised bench for sub_bytes_seq across lane counts and modes.
module tb_sub_bytes_seq;

    localparam int N_RAND = 1000;
    localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALL_52   = 128'h52525252525252525252525252525252;
    localparam logic [127:0] FIPS_IN  = 128'hf0e0d0c0b0a090807060504030201000;
    localparam logic [127:0] FIPS_SB  = 128'h8ce170bae7e060cd51d0530904b7ca63;
    localparam logic [127:0] SPOT_IN  = 128'h00000000000000000000000000000053;
    localparam logic [127:0] SPOT_INV = 128'h52525252525252525252525252525250;
    localparam logic [127:0] SPOT_FWD = 128'h636363636363636363636363636363ed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_sw_n;
    bit   tab_ready = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    logic         a_in_valid, a_in_ready, a_in_inverse, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_block, a_out_block;
    logic         b_in_valid, b_in_ready, b_in_inverse, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_block, b_out_block;

    sub_bytes_seq #(.LANES(4), .INV_EN(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_block(a_in_block), .in_inverse(a_in_inverse), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_block(a_out_block), .busy(a_busy)
    );

    sub_bytes_seq #(.LANES(1), .INV_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_block(b_in_block), .in_inverse(b_in_inverse), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_block(b_out_block), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input logic inv);
        logic [127:0] r = '0;
        for (int n = 0; n < 16; n++) begin
            r[n*8 +: 8] = inv ? inv_tab[blk[n*8 +: 8]] : fwd_tab[blk[n*8 +: 8]];
        end
        return r;
    endfunction

    task automatic run_blk(input bit sel, input logic [127:0] blk, input logic inv,
                           input int lat, input logic [127:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        if (sel) begin b_in_block = blk; b_in_inverse = inv; b_in_valid = 1'b1; end
        else     begin a_in_block = blk; a_in_inverse = inv; a_in_valid = 1'b1; end
        cyc = 0;
        while (!(sel ? b_in_ready : a_in_ready) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_accept"}, 128'(sel ? b_in_ready : a_in_ready), 128'd1);
        @(posedge clk); #1;
        if (sel) begin b_in_valid = 1'b0; b_in_inverse = ~inv; end
        else     begin a_in_valid = 1'b0; a_in_inverse = ~inv; end
        cyc = 0;
        while (!(sel ? b_out_valid : a_out_valid) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_data"}, sel ? b_out_block : a_out_block, exp);
        check({tag, "_busy"}, 128'(sel ? b_busy : a_busy), 128'd0);
        if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) b_out_ready = 1'b0; else a_out_ready = 1'b0;
        check({tag, "_drain"}, 128'(sel ? b_out_valid : a_out_valid), 128'd0);
    endtask

    for (genvar k = 0; k < 5; k++) begin : g_sw
        localparam int L  = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : (k == 3) ? 16 : 4;
        localparam bit IE = (k != 4);
        logic         iv, ir, ii, ov, ordy, bz;
        logic [127:0] ib, ob;
        logic [127:0] expq [$];
        bit           done = 1'b0;

        sub_bytes_seq #(.LANES(L), .INV_EN(IE)) u_dut (
            .clk(clk), .rst_n(rst_sw_n), .in_valid(iv), .in_ready(ir),
            .in_block(ib), .in_inverse(ii), .out_valid(ov),
            .out_ready(ordy), .out_block(ob), .busy(bz)
        );

        initial begin : src
            logic [127:0] blk;
            logic         inv;
            int           guard;
            iv = 1'b0; ib = '0; ii = 1'b0;
            wait (tab_ready);
            for (int i = 0; i < N_RAND; i++) begin
                @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                blk = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                iv = 1'b1; ib = blk; ii = inv;
                guard = 0;
                while (!ir && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 200) check($sformatf("sw%0d_accept_timeout", k), 128'd0, 128'd1);
                expq.push_back(model(blk, inv & IE));
                @(posedge clk); #1;
                iv = 1'b0;
                ii = 1'($urandom_range(0, 1));
                ib = {$urandom, $urandom, $urandom, $urandom};
            end
        end

        initial begin : snk
            logic [127:0] prev_blk;
            bit           hold;
            int           nout;
            int           idle;
            ordy = 1'b0; hold = 1'b0; nout = 0; idle = 0; prev_blk = '0;
            wait (tab_ready);
            while (nout < N_RAND && idle < 2000) begin
                @(posedge clk); #1;
                ordy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (hold) begin
                    check($sformatf("sw%0d_hold_valid", k), 128'(ov), 128'd1);
                    check($sformatf("sw%0d_hold_data", k), ob, prev_blk);
                end
                if (ov) begin
                    if (ordy) begin
                        check($sformatf("sw%0d_pending", k), 128'(expq.size() > 0), 128'd1);
                        if (expq.size() > 0) check($sformatf("sw%0d_data", k), ob, expq.pop_front());
                        check($sformatf("sw%0d_busy", k), 128'(bz), 128'd0);
                        nout++;
                        idle = 0;
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        prev_blk = ob;
                    end
                end else begin
                    hold = 1'b0;
                    idle++;
                end
            end
            if (nout < N_RAND) check($sformatf("sw%0d_output_timeout", k), 128'(nout), 128'(N_RAND));
            ordy = 1'b0;
            done = 1'b1;
        end
    end

    initial begin : main
        logic [7:0] gi;
        logic [7:0] s;
        int         cyc;
        rst_n = 1'b0; rst_sw_n = 1'b0;
        a_in_valid = 1'b0; a_in_inverse = 1'b0; a_in_block = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_inverse = 1'b0; b_in_block = '0; b_out_ready = 1'b0;

        // Reference S-box from GF(2^8) inversion plus the affine transform.
        for (int a = 0; a < 256; a++) begin
            gi = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(8'(a), 8'(b)) == 8'h01) gi = 8'(b);
            end
            s = gi ^ {gi[6:0], gi[7]} ^ {gi[5:0], gi[7:6]} ^ {gi[4:0], gi[7:5]}
                   ^ {gi[3:0], gi[7:4]} ^ 8'h63;
            fwd_tab[a] = s;
            inv_tab[s] = 8'(a);
        end

        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(a_out_valid), 128'd0);
        check("rst_in_ready", 128'(a_in_ready), 128'd1);
        check("rst_busy", 128'(a_busy), 128'd0);
        check("rst_out_block", a_out_block, 128'd0);
        rst_n = 1'b1; rst_sw_n = 1'b1;
        tab_ready = 1'b1;

        run_blk(1'b0, 128'd0, 1'b0, 4, ALL_63, "zero_fwd");
        run_blk(1'b0, FIPS_IN, 1'b0, 4, FIPS_SB, "fips_fwd");
        run_blk(1'b0, FIPS_SB, 1'b1, 4, FIPS_IN, "fips_inv");
        run_blk(1'b0, SPOT_IN, 1'b1, 4, SPOT_INV, "spot_inv");
        run_blk(1'b0, SPOT_IN, 1'b0, 4, SPOT_FWD, "spot_fwd");

        // Backpressure in DONE, then back-to-back accept on release.
        @(negedge clk);
        a_in_block = FIPS_IN; a_in_inverse = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_block = 128'd0; a_in_inverse = 1'b1;
        cyc = 0;
        while (!a_out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", 128'(cyc), 128'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 128'(a_out_valid), 128'd1);
            check("bp_hold_data", a_out_block, FIPS_SB);
            check("bp_hold_in_ready", 128'(a_in_ready), 128'd0);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(a_in_ready), 128'd1);
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_in_valid = 1'b0;
        check("b2b_busy", 128'(a_busy), 128'd1);
        check("b2b_out_valid", 128'(a_out_valid), 128'd0);
        cyc = 0;
        while (!a_out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_latency", 128'(cyc), 128'd4);
        check("b2b_data", a_out_block, ALL_52);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;

        // Asynchronous reset in the middle of a LANES=1 pass.
        @(negedge clk);
        b_in_block = FIPS_IN; b_in_inverse = 1'b0; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("mid_busy", 128'(b_busy), 128'd1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(b_out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(b_in_ready), 128'd1);
        check("mid_rst_busy", 128'(b_busy), 128'd0);
        check("mid_rst_out_block", b_out_block, 128'd0);
        check("mid_rst_other_block", a_out_block, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_blk(1'b1, FIPS_IN, 1'b0, 16, FIPS_SB, "lanes1_fwd");
        run_blk(1'b1, FIPS_SB, 1'b1, 16, FIPS_IN, "lanes1_inv");

        cyc = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done)
               && cyc < 80000) begin
            @(posedge clk);
            cyc++;
        end
        check("sweep_complete", 128'(g_sw[0].done && g_sw[1].done && g_sw[2].done
                                    && g_sw[3].done && g_sw[4].done), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
